// File: rtl/fsmc_sdr_bridge.sv
// rtl/fsmc_sdr_bridge.sv - FSMC async SRAM bus to SDRAM controller request-port bridge
module fsmc_sdr_bridge #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     fsmc_a,
    inout  wire  [DATA_W-1:0]     fsmc_d,
    input  logic                  fsmc_ne1,
    input  logic                  fsmc_nwe,
    input  logic                  fsmc_noe,
    input  logic [DATA_W/8-1:0]   fsmc_nbl,
    output logic                  fsmc_nwait,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  wr_overflow
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        RD_HOLD
    } state_t;

    // Strobe synchronisers reset to the inactive (high) level so no edge is seen out of reset.
    logic [SYNC_STAGES-1:0] ne_sync_q, we_sync_q, oe_sync_q;
    logic                   we_prev_q, oe_prev_q;
    logic                   ne_s, we_s, oe_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            ne_sync_q <= '1;
            we_sync_q <= '1;
            oe_sync_q <= '1;
            we_prev_q <= 1'b1;
            oe_prev_q <= 1'b1;
        end else begin
            ne_sync_q <= {ne_sync_q[SYNC_STAGES-2:0], fsmc_ne1};
            we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], fsmc_nwe};
            oe_sync_q <= {oe_sync_q[SYNC_STAGES-2:0], fsmc_noe};
            we_prev_q <= we_s;
            oe_prev_q <= oe_s;
        end
    end

    assign ne_s = ne_sync_q[SYNC_STAGES-1];
    assign we_s = we_sync_q[SYNC_STAGES-1];
    assign oe_s = oe_sync_q[SYNC_STAGES-1];

    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic [BE_W-1:0]   nbl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            d_q   <= '0;
            nbl_q <= '1;
        end else begin
            a_q   <= fsmc_a;
            d_q   <= fsmc_d;
            nbl_q <= fsmc_nbl;
        end
    end

    logic wr_det, rd_det;
    assign wr_det = !ne_s && we_prev_q && !we_s;
    assign rd_det = !ne_s && oe_prev_q && !oe_s;

    // Posted-write FIFO
    logic [ADDR_W-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q  [FIFO_DEPTH];
    logic [BE_W-1:0]   fifo_be_q    [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push       = wr_det && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= a_q;
            fifo_data_q[wr_ptr_q] <= d_q;
            fifo_be_q[wr_ptr_q]   <= ~nbl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wr_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (wr_det && fifo_full) wr_overflow <= 1'b1;
        end
    end

    // Request FSM and registered request port
    state_t            state_q, state_d;
    logic              req_q, req_d, we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q;
    logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              rd_pend_q, rd_pend_clr;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rd_data_d   = rd_data_q;
        pop         = 1'b0;
        rd_pend_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty)    state_d = WR_ISSUE;
                else if (rd_pend_q) state_d = RD_ISSUE;
            end
            WR_ISSUE: begin
                if (!req_q) begin
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = fifo_addr_q[rd_ptr_q];
                    wdata_d = fifo_data_q[rd_ptr_q];
                    be_d    = fifo_be_q[rd_ptr_q];
                end else if (mem_ack) begin
                    req_d   = 1'b0;
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = rd_addr_q;
                    be_d   = '1;
                end else if (mem_ack) begin
                    req_d       = 1'b0;
                    rd_pend_clr = 1'b1;
                    state_d     = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rd_data_d = mem_rdata;
                    state_d   = RD_HOLD;
                end
            end
            RD_HOLD: begin
                // Leaving here also covers the aborted read: data was fetched but is never driven.
                if (ne_s || oe_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rd_data_q <= '0;
            rd_addr_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rd_data_q <= rd_data_d;
            if (rd_det) begin
                rd_addr_q <= a_q;
                rd_pend_q <= 1'b1;
            end else if (rd_pend_clr) begin
                rd_pend_q <= 1'b0;
            end
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

    assign fsmc_nwait = !(fifo_full || rd_pend_q ||
                          (state_q == RD_ISSUE) || (state_q == RD_WAIT));

    logic d_oe;
    assign d_oe   = (state_q == RD_HOLD) && !fsmc_ne1 && !fsmc_noe;
    assign fsmc_d = d_oe ? rd_data_q : {DATA_W{1'bz}};

endmodule
